// File: rtl/picosoc_iomem_timer.sv
// Down-counting timer slave on the PicoSoC iomem bus with a prescaler, auto-reload or
// one-shot modes, and a level interrupt driven by the sticky STATUS flag.
module picosoc_iomem_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned PRE_WIDTH = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        timer_irq
);

  localparam int unsigned BUS_W = 32;
  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_PRESCALE = 3'd1;
  localparam logic [2:0] OFF_COUNT    = 3'd2;
  localparam logic [2:0] OFF_RELOAD   = 3'd3;
  localparam logic [2:0] OFF_STATUS   = 3'd4;

  // Byte-lane merge of a write into an existing register value
  function automatic logic [BUS_W-1:0] merge_bytes(input logic [BUS_W-1:0] old_v,
                                                   input logic [BUS_W-1:0] new_v,
                                                   input logic [3:0]       strb);
    logic [BUS_W-1:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  logic                 en, auto_reload, irq_en, flag;
  logic                 en_n, auto_reload_n, irq_en_n, flag_n;
  logic [PRE_WIDTH-1:0] prescale, pre_cnt, prescale_n, pre_cnt_n;
  logic [CNT_WIDTH-1:0] count, reload, count_n, reload_n;

  logic                 in_win, sel, wr, sel_rd;
  logic [2:0]           off;
  logic                 wr_ctrl, wr_prescale, wr_count, wr_reload, wr_status;
  logic                 tick, count_zero, hw_set, w1c;
  logic [2:0]           ctrl_w;
  logic [PRE_WIDTH-1:0] prescale_w;
  logic [CNT_WIDTH-1:0] count_w, reload_w;
  logic [BUS_W-1:0]     rd_val;
  logic                 unused_addr;

  // Window decode and handshake qualifiers; the !ready term makes each request 2 cycles
  assign in_win = (iomem_addr[31:5] == BASE_ADDR[31:5]);
  assign off    = iomem_addr[4:2];
  assign sel    = iomem_valid && in_win && !iomem_ready;
  assign wr     = sel && (iomem_wstrb != 4'b0000);
  assign sel_rd = sel && (iomem_wstrb == 4'b0000);
  assign unused_addr = ^iomem_addr[1:0];

  assign wr_ctrl     = wr && (off == OFF_CTRL);
  assign wr_prescale = wr && (off == OFF_PRESCALE);
  assign wr_count    = wr && (off == OFF_COUNT);
  assign wr_reload   = wr && (off == OFF_RELOAD);
  assign wr_status   = wr && (off == OFF_STATUS);

  assign ctrl_w     = 3'(merge_bytes(BUS_W'({irq_en, auto_reload, en}), iomem_wdata, iomem_wstrb));
  assign prescale_w = PRE_WIDTH'(merge_bytes(BUS_W'(prescale), iomem_wdata, iomem_wstrb));
  assign count_w    = CNT_WIDTH'(merge_bytes(BUS_W'(count), iomem_wdata, iomem_wstrb));
  assign reload_w   = CNT_WIDTH'(merge_bytes(BUS_W'(reload), iomem_wdata, iomem_wstrb));

  assign tick       = en && (pre_cnt == prescale);
  assign count_zero = (count == '0);
  assign hw_set     = tick && count_zero;
  assign w1c        = wr_status && iomem_wstrb[0] && iomem_wdata[0];

  // Next-state: software writes win over tick effects, except a hardware flag set beats W1C
  always_comb begin
    en_n          = en;
    auto_reload_n = auto_reload;
    irq_en_n      = irq_en;
    flag_n        = flag;
    prescale_n    = prescale;
    pre_cnt_n     = pre_cnt + PRE_WIDTH'(1);
    count_n       = count;
    reload_n      = reload;

    if (wr_prescale || !en || tick) pre_cnt_n = '0;
    if (wr_prescale) prescale_n = prescale_w;
    if (wr_reload)   reload_n   = reload_w;

    if (wr_ctrl) begin
      en_n          = ctrl_w[0];
      auto_reload_n = ctrl_w[1];
      irq_en_n      = ctrl_w[2];
    end else if (hw_set && !auto_reload) begin
      en_n = 1'b0;
    end

    if (wr_count) begin
      count_n = count_w;
    end else if (tick) begin
      if (!count_zero)      count_n = count - CNT_WIDTH'(1);
      else if (auto_reload) count_n = reload;
    end

    if (hw_set)   flag_n = 1'b1;
    else if (w1c) flag_n = 1'b0;
  end

  // Read mux; reserved offsets fall through to zero
  always_comb begin
    rd_val = '0;
    case (off)
      OFF_CTRL:     rd_val = BUS_W'({irq_en, auto_reload, en});
      OFF_PRESCALE: rd_val = BUS_W'(prescale);
      OFF_COUNT:    rd_val = BUS_W'(count);
      OFF_RELOAD:   rd_val = BUS_W'(reload);
      OFF_STATUS:   rd_val = BUS_W'(flag);
      default:      rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      en          <= 1'b0;
      auto_reload <= 1'b0;
      irq_en      <= 1'b0;
      flag        <= 1'b0;
      prescale    <= '0;
      pre_cnt     <= '0;
      count       <= '0;
      reload      <= '0;
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
    end else begin
      en          <= en_n;
      auto_reload <= auto_reload_n;
      irq_en      <= irq_en_n;
      flag        <= flag_n;
      prescale    <= prescale_n;
      pre_cnt     <= pre_cnt_n;
      count       <= count_n;
      reload      <= reload_n;
      iomem_ready <= sel;
      iomem_rdata <= sel_rd ? rd_val : '0;
    end
  end

  // Both terms are flops, so the interrupt never follows bus activity combinationally
  assign timer_irq = flag && irq_en;

endmodule

// File: tb/tb_picosoc_iomem_timer.sv
// Bench for picosoc_iomem_timer: register-access vector table plus cycle-exact
// sequences for periodic, one-shot, collision and reset behaviour.
module tb_picosoc_iomem_timer;

  localparam logic [31:0] BASE = 32'h0300_0000;
  localparam logic [4:0] O_CTRL = 5'h00, O_PRE = 5'h04, O_CNT = 5'h08, O_REL = 5'h0C, O_STAT = 5'h10;

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid;
  logic        ready;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  strb;
    logic [4:0]  off;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  picosoc_iomem_timer dut (
    .clk         (clk),
    .resetn      (resetn),
    .iomem_valid (valid),
    .iomem_ready (ready),
    .iomem_wstrb (wstrb),
    .iomem_addr  (addr),
    .iomem_wdata (wdata),
    .iomem_rdata (rdata),
    .timer_irq   (irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One request; starts #1 after an edge, commits on the next edge, returns #1 after the one after
  task automatic bus(input logic [3:0] strb, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output int waited, output logic rdy_after);
    valid = 1'b1; wstrb = strb; addr = a; wdata = d;
    waited = 0; rd = '0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (ready) begin
        waited = i;
        rd = rdata;
        break;
      end
    end
    valid = 1'b0; wstrb = 4'h0;
    @(posedge clk); #1;
    rdy_after = ready;
  endtask

  task automatic wr(input logic [4:0] off, input logic [31:0] d);
    logic [31:0] rd; int w; logic ra;
    bus(4'hF, BASE + 32'(off), d, rd, w, ra);
  endtask

  task automatic rd_chk(input string name, input logic [4:0] off, input logic [31:0] exp);
    logic [31:0] rd; int w; logic ra;
    bus(4'h0, BASE + 32'(off), 32'h0, rd, w, ra);
    check(name, rd, exp);
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    int          waited;
    logic        ra;

    for (int o = 0; o < 32; o += 4) vecs.push_back('{4'h0, 5'(o), 32'h0, 32'h0});
    vecs.push_back('{4'b0010, O_REL, 32'hAABB_CCDD, 32'h0});
    vecs.push_back('{4'h0, O_REL, 32'h0, 32'h0000_CC00});
    vecs.push_back('{4'h0, 5'h0F, 32'h0, 32'h0000_CC00});
    vecs.push_back('{4'hF, O_PRE, 32'hFFFF_FFFF, 32'h0});
    vecs.push_back('{4'h0, O_PRE, 32'h0, 32'h0000_FFFF});
    vecs.push_back('{4'hF, O_CTRL, 32'hFFFF_FFFE, 32'h0});
    vecs.push_back('{4'h0, O_CTRL, 32'h0, 32'h0000_0006});
    vecs.push_back('{4'hF, O_CTRL, 32'h0, 32'h0});
    vecs.push_back('{4'hF, 5'h14, 32'hFFFF_FFFF, 32'h0});
    vecs.push_back('{4'h0, 5'h14, 32'h0, 32'h0});
    vecs.push_back('{4'hF, O_CNT, 32'h1234_5678, 32'h0});
    vecs.push_back('{4'h0, O_CNT, 32'h0, 32'h1234_5678});
    vecs.push_back('{4'b1000, O_CNT, 32'h9900_0000, 32'h0});
    vecs.push_back('{4'h0, O_CNT, 32'h0, 32'h9934_5678});
    vecs.push_back('{4'hF, O_STAT, 32'h1, 32'h0});
    vecs.push_back('{4'h0, O_STAT, 32'h0, 32'h0});
    vecs.push_back('{4'hF, O_CNT, 32'h0, 32'h0});
    vecs.push_back('{4'hF, O_PRE, 32'h0, 32'h0});
    vecs.push_back('{4'hF, O_REL, 32'h0, 32'h0});

    resetn = 1'b0; valid = 1'b0; wstrb = 4'h0; addr = 32'h0; wdata = 32'h0;
    wait_edges(3);
    check("reset ready", 32'(ready), 32'h0);
    check("reset rdata", rdata, 32'h0);
    check("reset irq", 32'(irq), 32'h0);
    resetn = 1'b1;
    wait_edges(1);

    // Register access table
    foreach (vecs[i]) begin
      bus(vecs[i].strb, BASE + 32'(vecs[i].off), vecs[i].data, rd, waited, ra);
      check($sformatf("ack latency v%0d", i), 32'(waited), 32'd1);
      check($sformatf("ack width v%0d", i), 32'(ra), 32'd0);
      if (vecs[i].strb == 4'h0) check($sformatf("rdata v%0d", i), rd, vecs[i].exp);
    end
    check("irq idle", 32'(irq), 32'h0);

    // Periodic: enable commits on E0, wr returns after E1
    wr(O_REL, 4); wr(O_PRE, 0); wr(O_CNT, 4); wr(O_CTRL, 32'h7);
    for (int e = 2; e <= 5; e++) begin
      wait_edges(1);
      check($sformatf("periodic irq E%0d", e), 32'(irq), 32'(e == 5));
    end
    wr(O_STAT, 1);
    check("periodic w1c", 32'(irq), 32'h0);
    for (int e = 8; e <= 10; e++) begin
      wait_edges(1);
      check($sformatf("periodic irq E%0d", e), 32'(irq), 32'(e == 10));
    end
    wr(O_CTRL, 0); wr(O_STAT, 1);
    check("periodic stopped", 32'(irq), 32'h0);

    // One-shot with prescaler 2: ticks on E3, E6, E9, E12
    wr(O_PRE, 2); wr(O_CNT, 3); wr(O_CTRL, 32'h5);
    for (int e = 2; e <= 12; e++) begin
      wait_edges(1);
      check($sformatf("oneshot irq E%0d", e), 32'(irq), 32'(e == 12));
    end
    rd_chk("oneshot ctrl", O_CTRL, 32'h4);
    rd_chk("oneshot count", O_CNT, 32'h0);
    rd_chk("oneshot status", O_STAT, 32'h1);
    wait_edges(5);
    rd_chk("oneshot count held", O_CNT, 32'h0);
    wr(O_STAT, 1); wr(O_CTRL, 0);

    // COUNT write lands on the tick edge E10
    wr(O_PRE, 9); wr(O_CNT, 5); wr(O_CTRL, 32'h1);
    wait_edges(8);
    wr(O_CNT, 32'h10);
    rd_chk("count write vs tick", O_CNT, 32'h10);
    wr(O_CTRL, 0);

    // W1C lands on the flag-set edge E10
    wr(O_PRE, 9); wr(O_CNT, 0); wr(O_CTRL, 32'h5);
    wait_edges(8);
    wr(O_STAT, 1);
    rd_chk("flag set vs w1c", O_STAT, 32'h1);
    check("flag set irq", 32'(irq), 32'h1);
    rd_chk("oneshot en clear", O_CTRL, 32'h4);
    wr(O_STAT, 1);
    rd_chk("status cleared", O_STAT, 32'h0);

    // CTRL write lands on the one-shot expiry edge E10
    wr(O_CNT, 0); wr(O_CTRL, 32'h5);
    wait_edges(8);
    wr(O_CTRL, 32'h5);
    rd_chk("ctrl write vs en clear", O_CTRL, 32'h5);
    wr(O_CTRL, 0); wr(O_STAT, 1);

    // Out-of-window traffic is ignored
    bus(4'h0, 32'h0400_0000, 32'h0, rd, waited, ra);
    check("oow no ack", 32'(waited), 32'h0);
    check("oow ready", 32'(ra), 32'h0);

    // Asynchronous reset mid-transaction while running with irq high
    wr(O_REL, 4); wr(O_PRE, 0); wr(O_CNT, 4); wr(O_CTRL, 32'h7);
    wait_edges(4);
    check("pre-reset irq", 32'(irq), 32'h1);
    valid = 1'b1; wstrb = 4'h0; addr = BASE + 32'(O_CNT);
    @(posedge clk); #1;
    check("pre-reset ready", 32'(ready), 32'h1);
    #2 resetn = 1'b0;
    #1;
    check("async ready", 32'(ready), 32'h0);
    check("async irq", 32'(irq), 32'h0);
    check("async rdata", rdata, 32'h0);
    wstrb = 4'hF; wdata = 32'h55;
    wait_edges(2);
    valid = 1'b0; wstrb = 4'h0;
    resetn = 1'b1;
    wait_edges(1);
    rd_chk("post-reset ctrl", O_CTRL, 32'h0);
    rd_chk("post-reset prescale", O_PRE, 32'h0);
    rd_chk("post-reset count", O_CNT, 32'h0);
    rd_chk("post-reset reload", O_REL, 32'h0);
    rd_chk("post-reset status", O_STAT, 32'h0);
    check("post-reset irq", 32'(irq), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
